// File: rtl/dottori_pkg.sv
// dottori_pkg
//   Shared constants for the Dottori cabinet input path.
//   NUM_BUTTONS   : number of raw cabinet button lines
//   BTN_RELEASED  : idle level of an active-low button line
//   ALL_RELEASED  : whole-bus idle value (reset value of the button registers)
//   is_rise()     : one-sample rising-edge detect helper
package dottori_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam logic BTN_RELEASED = 1'b1;

    localparam logic [NUM_BUTTONS-1:0] ALL_RELEASED = {NUM_BUTTONS{BTN_RELEASED}};

    function automatic logic is_rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/dottori_input_conditioner_debounce_bit.sv
// dottori_debounce_bit
//   One cabinet button line: two-flop synchroniser, saturating debounce
//   counter, debounced level and a one-cycle press pulse.
//   Ports:
//     nCLK_4M   in  system pixel clock (rising edge used)
//     nRESET    in  asynchronous active-low reset
//     raw_n_i   in  raw asynchronous button line, active-low
//     stable_o  out debounced level, active-low
//     press_o   out one-cycle pulse when stable_o falls (button pressed)
module dottori_debounce_bit
    import dottori_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic nCLK_4M,
    input  logic nRESET,
    input  logic raw_n_i,
    output logic stable_o,
    output logic press_o
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    logic                     s1_q;
    logic                     s2_q;
    logic                     stable_q;
    logic                     stable_d;
    logic                     press_q;
    logic                     press_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic [DEBOUNCE_BITS-1:0] cnt_d;

    // The counter only advances while the synchronised line disagrees with
    // the debounced level; a single agreeing sample clears it, so a bounce
    // restarts qualification from scratch. Reaching CNT_MAX while still
    // disagreeing commits the new level instead of wrapping.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only the released->pressed transition is reported.
        press_d = (stable_q == BTN_RELEASED) && (stable_d != BTN_RELEASED);
    end

    always_ff @(posedge nCLK_4M or negedge nRESET) begin
        if (!nRESET) begin
            s1_q     <= BTN_RELEASED;
            s2_q     <= BTN_RELEASED;
            stable_q <= BTN_RELEASED;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= raw_n_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/dottori_input_conditioner.sv
// dottori_input_conditioner
//   Conditions the eight raw active-low cabinet buttons for the Z80 input
//   port: per-line synchronise + debounce, optional once-per-frame freeze of
//   the value seen by the CPU, and press pulses.
//   Parameters:
//     DEBOUNCE_BITS   debounce counter width (qualify time = 2^N-1 cycles)
//     LATCH_ON_FRAME  1: BUTTONS reloads on FRAME rising edge only
//                     0: BUTTONS is STABLE delayed by one cycle
//   Ports:
//     nCLK_4M       in  system pixel clock (rising edge used)
//     nRESET        in  asynchronous active-low reset
//     RAW_nBUTTONS  in  raw asynchronous button lines, active-low
//     FRAME         in  V_SYNC level, synchronous to nCLK_4M
//     BUTTONS       out conditioned buttons to the Z80 port read mux
//     STABLE        out debounced buttons before the frame latch
//     PRESS         out one-cycle press pulses, one per bit
module dottori_input_conditioner
    import dottori_pkg::*;
#(
    parameter int DEBOUNCE_BITS  = 14,
    parameter int LATCH_ON_FRAME = 1
) (
    input  logic                   nCLK_4M,
    input  logic                   nRESET,
    input  logic [NUM_BUTTONS-1:0] RAW_nBUTTONS,
    input  logic                   FRAME,
    output logic [NUM_BUTTONS-1:0] BUTTONS,
    output logic [NUM_BUTTONS-1:0] STABLE,
    output logic [NUM_BUTTONS-1:0] PRESS
);

    logic [NUM_BUTTONS-1:0] stable_w;
    logic [NUM_BUTTONS-1:0] press_w;
    logic [NUM_BUTTONS-1:0] buttons_q;
    logic [NUM_BUTTONS-1:0] buttons_d;
    logic                   frame_q;
    logic                   frame_rise;

    // Each line is fully independent.
    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            dottori_debounce_bit #(
                .DEBOUNCE_BITS(DEBOUNCE_BITS)
            ) u_bit (
                .nCLK_4M (nCLK_4M),
                .nRESET  (nRESET),
                .raw_n_i (RAW_nBUTTONS[gi]),
                .stable_o(stable_w[gi]),
                .press_o (press_w[gi])
            );
        end
    endgenerate

    // frame_q resets low so a FRAME already high out of reset counts as a
    // rise on the first edge. BUTTONS loads the pre-edge STABLE, so a
    // debounce commit landing on the same edge as the strobe waits a frame.
    assign frame_rise = is_rise(FRAME, frame_q);

    always_comb begin
        buttons_d = buttons_q;
        if (LATCH_ON_FRAME == 0) begin
            buttons_d = stable_w;
        end else if (frame_rise) begin
            buttons_d = stable_w;
        end
    end

    always_ff @(posedge nCLK_4M or negedge nRESET) begin
        if (!nRESET) begin
            frame_q   <= 1'b0;
            buttons_q <= ALL_RELEASED;
        end else begin
            frame_q   <= FRAME;
            buttons_q <= buttons_d;
        end
    end

    assign BUTTONS = buttons_q;
    assign STABLE  = stable_w;
    assign PRESS   = press_w;

endmodule

// File: tb/tb_dottori_input_conditioner.sv
module tb_dottori_input_conditioner;

    localparam int DB   = 2;
    localparam int MAXV = 3;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] raw = 8'hFF;
    logic       frame = 1'b0;

    logic [7:0] b0, s0, p0;   // LATCH_ON_FRAME = 0
    logic [7:0] b1, s1, p1;   // LATCH_ON_FRAME = 1

    dottori_input_conditioner #(.DEBOUNCE_BITS(DB), .LATCH_ON_FRAME(0)) dut0 (
        .nCLK_4M(clk), .nRESET(nrst), .RAW_nBUTTONS(raw), .FRAME(frame),
        .BUTTONS(b0), .STABLE(s0), .PRESS(p0)
    );

    dottori_input_conditioner #(.DEBOUNCE_BITS(DB), .LATCH_ON_FRAME(1)) dut1 (
        .nCLK_4M(clk), .nRESET(nrst), .RAW_nBUTTONS(raw), .FRAME(frame),
        .BUTTONS(b1), .STABLE(s1), .PRESS(p1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: a bit commits when its synchronised sample has
    // disagreed with the debounced level on each of the last MAX+1 edges.
    logic [7:0] m_stable, m_press, m_btn0, m_btn1;
    logic       m_fprev;
    logic [7:0] rawq[$];   // RAW as seen at each edge since reset
    logic [7:0] s2q[$];    // synchronised sample window, newest last

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = 8'hFF;
        m_press  = 8'h00;
        m_btn0   = 8'hFF;
        m_btn1   = 8'hFF;
        m_fprev  = 1'b0;
        rawq.delete();
        s2q.delete();
    endtask

    task automatic model_edge(input logic [7:0] r, input logic f);
        logic [7:0] s2pre, nst;
        bit         all_diff;
        // Two-flop delay: the sample used at this edge is RAW from two edges ago.
        s2pre = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 8'hFF;
        s2q.push_back(s2pre);
        if (s2q.size() > MAXV + 1) void'(s2q.pop_front());
        nst = m_stable;
        if (s2q.size() == MAXV + 1) begin
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                foreach (s2q[j]) if (s2q[j][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) nst[i] = ~m_stable[i];
            end
        end
        m_press = m_stable & ~nst;
        m_btn0  = m_stable;
        if (f && !m_fprev) m_btn1 = m_stable;
        m_fprev  = f;
        m_stable = nst;
        rawq.push_back(r);
        if (rawq.size() > 4) void'(rawq.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".stable0"},  s0, m_stable);
        chk({tag, ".press0"},   p0, m_press);
        chk({tag, ".buttons0"}, b0, m_btn0);
        chk({tag, ".stable1"},  s1, m_stable);
        chk({tag, ".press1"},   p1, m_press);
        chk({tag, ".buttons1"}, b1, m_btn1);
    endtask

    task automatic step(input logic [7:0] r, input logic f, input string tag);
        raw   = r;
        frame = f;
        @(posedge clk);
        model_edge(r, f);
        #1;
        check_all(tag);
        $display("step %-10s raw=%h frame=%0d stable=%h press=%h btn0=%h btn1=%h",
                 tag, r, f, s0, p0, b0, b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".stable0"},  s0, 8'hFF);
        chk({tag, ".press0"},   p0, 8'h00);
        chk({tag, ".buttons0"}, b0, 8'hFF);
        chk({tag, ".stable1"},  s1, 8'hFF);
        chk({tag, ".press1"},   p1, 8'h00);
        chk({tag, ".buttons1"}, b1, 8'hFF);
    endtask

    task automatic release_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        logic       f;

        // Reset with every button held down.
        model_reset();
        raw  = 8'h00;
        nrst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_reset_values("reset");
        end

        // Clean press of bit 0, RAW settled before edge 1.
        raw = 8'hFE;
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            step(8'hFE, 1'b0, "press");
            if (k == 5) chk("press.no_early", s0, 8'hFF);
            if (k == 6) begin
                chk("press.flip",     s0, 8'hFE);
                chk("press.pulse",    p0, 8'h01);
                chk("press.btn_lag",  b0, 8'hFF);
            end
            if (k == 7) begin
                chk("press.one_cycle", p0, 8'h00);
                chk("press.btn0",      b0, 8'hFE);
                chk("press.btn1_hold", b1, 8'hFF);
            end
        end

        // Frame latch: rise captures, held-high FRAME captures once only.
        step(8'hFE, 1'b1, "frame_rise");
        chk("frame.capture", b1, 8'hFE);
        for (int k = 1; k <= 8; k++) step(8'hFC, 1'b1, "frame_hold");
        chk("frame.stable_fc", s1, 8'hFC);
        chk("frame.held",      b1, 8'hFE);
        step(8'hFC, 1'b0, "frame_low");
        step(8'hFC, 1'b1, "frame_rise2");
        chk("frame.next_rise", b1, 8'hFC);

        // Bounce on bit 3: low 3, high 1, then low steady.
        for (int k = 1; k <= 12; k++) begin
            r = (k == 4) ? 8'hFC : 8'hF4;
            step(r, 1'b0, "bounce");
            if (k == 6 || k == 9) chk("bounce.no_early", s0 & 8'h08, 8'h08);
            if (k == 10) begin
                chk("bounce.flip",  s0 & 8'h08, 8'h00);
                chk("bounce.pulse", p0, 8'h08);
            end
        end

        // Collision: bit 0 release commits on the same edge FRAME rises.
        for (int k = 1; k <= 6; k++) step(8'hF5, (k == 6), "collide");
        chk("collide.stable", s1, 8'hF5);
        chk("collide.old",    b1, 8'hF4);
        step(8'hF5, 1'b1, "collide_hi");
        chk("collide.held", b1, 8'hF4);
        step(8'hF5, 1'b0, "collide_lo");
        step(8'hF5, 1'b1, "collide_nx");
        chk("collide.new", b1, 8'hF5);

        // Mid-qualification reset with bit 7 held.
        for (int k = 1; k <= 4; k++) step(8'h75, 1'b0, "pre_rst");
        nrst = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("in_rst");
        release_reset();
        for (int k = 1; k <= 7; k++) begin
            step(8'h75, 1'b0, "requal");
            if (k == 5) chk("requal.no_early", s0, 8'hFF);
            if (k == 6) chk("requal.flip",     s0, 8'h75);
        end

        // Randomised traffic against the model.
        r = 8'h75;
        f = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) r = $urandom();
            if ($urandom_range(0, 5) == 0) f = ~f;
            step(r, f, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
